// File: rtl/arith_lab_pkg.sv
// arith_lab_pkg: shared types and defaults for the arithmetic lab datapath
package arith_lab_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        NEXT,
        CMP_MIN,
        CMP_MAX,
        DONE
    } mm_state_t;

endpackage

// File: rtl/mag_comp.sv
// mag_comp: combinational unsigned magnitude comparator
module mag_comp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             altb,
    output logic             agtb,
    output logic             aeqb
);

    assign altb = a < b;
    assign agtb = a > b;
    assign aeqb = a == b;

endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: frame min/max finder sharing one comparator between both searches
module minmax_tracker
    import arith_lab_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN = 8,
    localparam int IW = $clog2(LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [IW-1:0]    min_idx,
    output logic [IW-1:0]    max_idx
);

    mm_state_t        state, state_n;
    logic [WIDTH-1:0] hold;
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] comp_b;
    logic             altb, agtb, aeqb;
    logic             upd;
    logic             last;

    assign comp_b = (state == CMP_MAX) ? max_out : min_out;
    assign last   = cnt == IW'(LEN - 1);
    // strict compare only: a tie never replaces the earlier index
    assign upd    = ((state == CMP_MIN) ? altb : agtb) && !aeqb;

    assign in_ready = (state == FIRST) || (state == NEXT);
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    mag_comp #(.WIDTH(WIDTH)) u_comp (
        .a    (hold),
        .b    (comp_b),
        .altb (altb),
        .agtb (agtb),
        .aeqb (aeqb)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FIRST : IDLE;
            FIRST:   state_n = in_valid ? NEXT : FIRST;
            NEXT:    state_n = in_valid ? CMP_MIN : NEXT;
            CMP_MIN: state_n = CMP_MAX;
            CMP_MAX: state_n = last ? DONE : NEXT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // sample capture, result registers and sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_out <= '0;
            max_out <= '0;
            min_idx <= '0;
            max_idx <= '0;
            hold    <= '0;
            cnt     <= '0;
        end else begin
            if (state == FIRST && in_valid) begin
                min_out <= in_data;
                max_out <= in_data;
                min_idx <= '0;
                max_idx <= '0;
                cnt     <= IW'(1);
            end
            if (state == NEXT && in_valid)
                hold <= in_data;
            if (state == CMP_MIN && upd) begin
                min_out <= hold;
                min_idx <= cnt;
            end
            if (state == CMP_MAX) begin
                if (upd) begin
                    max_out <= hold;
                    max_idx <= cnt;
                end
                if (!last)
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: randomized and directed checks against a first-occurrence min/max model
module tb_minmax_tracker;

    localparam int W = 4;
    localparam int L = 8;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         start = 0, in_valid = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, busy, done;
    logic [W-1:0] min_out, max_out;
    logic [2:0]   min_idx, max_idx;

    logic         s2 = 0, v2 = 0;
    logic [W-1:0] d2 = '0;
    logic         rdy2, busy2, done2;
    logic [W-1:0] min2, max2;
    logic [0:0]   mi2, ma2;

    int total = 0, bad = 0;
    int cyc = 0, xfers = 0, dones = 0;
    int vals[16];

    minmax_tracker #(.WIDTH(W), .LEN(L)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done), .min_out(min_out), .max_out(max_out),
        .min_idx(min_idx), .max_idx(max_idx)
    );

    minmax_tracker #(.WIDTH(W), .LEN(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .in_valid(v2), .in_data(d2),
        .in_ready(rdy2), .busy(busy2), .done(done2), .min_out(min2), .max_out(max2),
        .min_idx(mi2), .max_idx(ma2)
    );

    always #5 clk = ~clk;

    // free-running edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // count handshakes and done pulses mid-cycle, where inputs and state are stable
    always @(negedge clk) begin
        if (in_valid && in_ready) xfers <= xfers + 1;
        if (done) dones <= dones + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: idle cycles before each sample; rnd: random gaps; poke: pulse start in a CMP_MAX;
    // abort: reset right after this many samples (0 = run to completion)
    task automatic run_frame(input string tag, input int gap, input bit rnd, input bit poke,
                             input int abort);
        int t0, g, wn, emin, emax, eimin, eimax;
        emin = vals[0]; emax = vals[0]; eimin = 0; eimax = 0;
        for (int i = 1; i < L; i++) begin
            if (vals[i] < emin) begin emin = vals[i]; eimin = i; end
            if (vals[i] > emax) begin emax = vals[i]; eimax = i; end
        end
        xfers = 0;
        dones = 0;
        start = 1;
        tick();
        t0 = cyc;
        start = 0;
        for (int i = 0; i < L; i++) begin
            g = rnd ? int'($urandom_range(0, 2)) : gap;
            in_valid = 0;
            repeat (g) tick();
            in_valid = 1;
            in_data = W'(vals[i]);
            wn = 0;
            while (!in_ready && wn < 50) begin
                tick();
                wn++;
                start = poke && i == 3 && wn == 1;
            end
            start = 0;
            if (wn >= 50) begin
                check({tag, "_rdy_timeout"}, wn, 0);
                in_valid = 0;
                return;
            end
            tick();
            if (i > 0) check({tag, "_rdy_cmp"}, int'(in_ready), 0);
            if (abort == i + 1) begin
                in_valid = 0;
                rst_n = 0;
                #1;
                check({tag, "_abort_busy"}, int'(busy), 0);
                check({tag, "_abort_min"}, int'(min_out), 0);
                check({tag, "_abort_max"}, int'(max_out), 0);
                repeat (3) tick();
                rst_n = 1;
                tick();
                check({tag, "_abort_dones"}, dones, 0);
                return;
            end
        end
        in_valid = 0;
        wn = 0;
        while (!done && wn < 60) begin
            tick();
            wn++;
        end
        check({tag, "_done_seen"}, int'(done), 1);
        if (gap == 0 && !rnd) check({tag, "_lat"}, cyc - t0, 1 + 3 * (L - 1));
        check({tag, "_min"}, int'(min_out), emin);
        check({tag, "_minidx"}, int'(min_idx), eimin);
        check({tag, "_max"}, int'(max_out), emax);
        check({tag, "_maxidx"}, int'(max_idx), eimax);
        repeat (poke ? 10 : 1) tick();
        check({tag, "_idle"}, int'(busy), 0);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_xfers"}, xfers, L);
        check({tag, "_hold_min"}, int'(min_out), emin);
        check({tag, "_hold_max"}, int'(max_out), emax);
    endtask

    initial begin
        int t, wn;
        repeat (2) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_min", int'(min_out), 0);
        check("rst_max", int'(max_out), 0);
        check("rst_idx", int'({min_idx, max_idx}), 0);
        rst_n = 1;
        tick();
        check("idle_busy", int'(busy), 0);

        vals[0:7] = '{5, 3, 9, 3, 0, 15, 15, 7};
        run_frame("b2b", 0, 0, 0, 0);

        vals[0:7] = '{6, 6, 6, 6, 6, 6, 6, 6};
        run_frame("flat", 0, 0, 0, 0);

        vals[0:7] = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame("stall", 3, 0, 0, 0);

        vals[0:7] = '{4, 11, 2, 13, 8, 1, 14, 6};
        run_frame("poke", 0, 0, 1, 0);

        vals[0:7] = '{5, 3, 9, 3, 0, 15, 15, 7};
        run_frame("abort", 0, 0, 0, 4);
        vals[0:7] = '{2, 2, 2, 2, 2, 2, 2, 1};
        run_frame("after", 0, 0, 0, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < L; i++) vals[i] = int'($urandom_range(0, 15));
            run_frame($sformatf("rnd%0d", f), 0, 1, 0, 0);
        end

        s2 = 1;
        tick();
        t = cyc;
        s2 = 0;
        v2 = 1;
        d2 = 4'd15;
        tick();
        d2 = 4'd0;
        wn = 0;
        while (!rdy2 && wn < 20) begin tick(); wn++; end
        tick();
        v2 = 0;
        wn = 0;
        while (!done2 && wn < 20) begin tick(); wn++; end
        check("len2_done", int'(done2), 1);
        check("len2_lat", cyc - t, 4);
        check("len2_min", int'(min2), 0);
        check("len2_minidx", int'(mi2), 1);
        check("len2_max", int'(max2), 15);
        check("len2_maxidx", int'(ma2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
